t5_hart_sched: RTL

- Barrel-hart scheduler for the 4-hart fetch stage.
- Owns the per-hart run state and the rotating hart slot. Decides each slot whether the fetch stage issues a real fetch, a boot-vector fetch, or a bubble.
- Generates the fetch-stage advance enable. Stalls the rotation while an issued fetch waits on the instruction bus.

---
 rtl/t5_hart_sched_if.sv | 20 ++
 rtl/t5_hart_sched.sv | 99 +++++++++
 2 files changed

// File: rtl/t5_hart_sched_if.sv
// Fetch-side handshake between the hart scheduler and the fetch stage.
// The scheduler drives the slot and the enables; the bus returns iack.
interface t5_hart_sched_if;
    logic [1:0] hart;
    logic       issue;
    logic       boot;
    logic       adv;
    logic       stall;
    logic       iack;

    modport master (
        output hart, issue, boot, adv, stall,
        input  iack
    );

    modport slave (
        input  hart, issue, boot, adv, stall,
        output iack
    );
endinterface

// File: rtl/t5_hart_sched.sv
// Barrel-hart scheduler for the 4-hart fetch stage.
// Optional stall timeout: define T5_STALL_TMO_EN.
module t5_hart_sched #(
    parameter logic [3:0] RESET_MASK = 4'b0001,
    parameter int         TMO_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [3:0]       start,
    input  logic [3:0]       halt,
    input  logic             wfi,
    input  logic [1:0]       wfi_hart,
    input  logic [3:0]       irq,
    output logic [7:0]       status,
    output logic             err,
    t5_hart_sched_if.master  fe
);
    typedef enum logic [1:0] {
        OFF   = 2'b00,
        RUN   = 2'b01,
        SLEEP = 2'b10,
        BOOT  = 2'b11
    } hst_t;

    hst_t       st [4];
    hst_t       cur;
    logic [1:0] hart;
    logic       issue;
    logic       adv;
    logic       stall;
    logic       tmo;

    always_comb begin
        cur   = st[hart];
        issue = (cur == RUN) || (cur == BOOT);
        adv   = ena & (fe.iack | ~issue);
        stall = ena & issue & ~fe.iack;
    end

    assign fe.hart  = hart;
    assign fe.issue = issue;
    assign fe.boot  = (cur == BOOT);
    assign fe.adv   = adv;
    assign fe.stall = stall;
    assign status   = {st[3], st[2], st[1], st[0]};

`ifdef T5_STALL_TMO_EN
    localparam logic [TMO_W-1:0] TMAX = '1;
    logic [TMO_W-1:0] cnt;

    // Fires on the stall cycle that would take the counter to all-ones.
    assign tmo = stall && (cnt == TMAX - 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (adv || tmo) begin
            cnt <= '0;
        end else if (stall) begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    assign err = tmo;

    always_ff @(posedge clk) begin
        if (rst) begin
            hart <= 2'b00;
            for (int i = 0; i < 4; i++) begin
                st[i] <= RESET_MASK[i] ? BOOT : OFF;
            end
        end else begin
            // Gray-style rotation 00 -> 01 -> 11 -> 10.
            if (adv) begin
                hart <= {hart[0], ~hart[1]};
            end
            for (int i = 0; i < 4; i++) begin
                if (halt[i]) begin
                    st[i] <= OFF;
                end else if (tmo && hart == 2'(i)) begin
                    st[i] <= OFF;
                end else if (start[i] && st[i] == OFF) begin
                    st[i] <= BOOT;
                end else if (st[i] == BOOT && hart == 2'(i) && adv) begin
                    st[i] <= RUN;
                end else if (st[i] == RUN && wfi &&
                             wfi_hart == 2'(i) && !irq[i]) begin
                    st[i] <= SLEEP;
                end else if (st[i] == SLEEP && irq[i]) begin
                    st[i] <= RUN;
                end
            end
        end
    end
endmodule
